hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised hazard, forwarding and issue-control unit for the in-order RV32 pipeline; successor to the fixed two-operand stall/forward logic in the pipeline-register datapath.
- Owns an internal tracking pipeline of NFWD stages (execute onward) and a register scoreboard for variable-latency ("long") ops: loads, mul/div.
- Produces decode-stage operand forwarding, stall and issue signals, and a stall performance counter.
- Sits between decode, the register file and the execute/memory/writeback stages.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural registers; RAW = $clog2(NREG).
- NRP, 2, decode read ports.
- NFWD, 2, forwardable stages after decode; stage 0 = execute output, stage NFWD-1 = oldest.
- MAX_LONG, 4, maximum outstanding long ops (tag FIFO depth, power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_d_valid  in  1  decode holds a valid instruction
- i_d_rsa  in  NRP*RAW  source register addresses
- i_d_rs_used  in  NRP  per-port operand actually read
- i_d_rda  in  RAW  destination register
- i_d_rfwe  in  1  instruction writes rd
- i_d_long  in  1  variable-latency op
- i_d_jump  in  1  branch/jump resolved in decode; needs final operands
- i_flush  in  1  kill the decode-stage instruction
- i_hold  in  1  external global stall (memory wait)
- i_rf_data  in  NRP*XLEN  register-file read data
- i_stg_data  in  NFWD*XLEN  result value of each stage
- i_long_done  in  1  oldest long op completes this cycle
- i_long_data  in  XLEN  its result
- o_long_rda  out  RAW  rd of the oldest outstanding long op (FIFO head)
- o_fwd_data  out  NRP*XLEN  resolved operands
- o_fwd_sel  out  NRP*$clog2(NFWD+2)  source select (debug/trace)
- o_stall  out  1  decode must hold
- o_d_issue  out  1  instruction moves to execute this cycle
- o_long_full  out  1  tag FIFO full
- o_stall_cnt  out  32  saturating count of o_stall cycles

Behaviour:
- Reset: stage valids 0, busy vector 0, FIFO empty, o_stall_cnt 0, o_long_full 0. o_stall and o_d_issue are 0 until i_d_valid is asserted.
- Issue rule: o_d_issue = i_d_valid & !o_stall & !i_hold & !i_flush.
- Tracking pipeline: each entry is {valid, rda, rfwe, long}. When !i_hold the entries shift every cycle.
  - Stage 0 loads the decode entry if o_d_issue; otherwise it loads a bubble (valid=0).
  - When i_hold, the whole pipeline freezes.
- Scoreboard:
  - Set: on issue with i_d_long & i_d_rfwe & rda!=0, set busy[rda] and push rda into the tag FIFO.
  - Clear: i_long_done pops the FIFO head and clears busy[head]. Completion is accepted even under i_hold.
  - Same-cycle pop and push are both allowed; count is unchanged.
  - i_long_done while the FIFO is empty is ignored. This is an assertion-checked error.
- Per-port hazard (port p used, rsa!=0):
  - busy[rsa] and not (i_long_done & head==rsa) → stall.
  - i_d_jump and the stage-0 entry is valid & rfwe & rda==rsa → stall (execute result is too late for decode branch).
  - A stage entry with long=1 and a matching rda never forwards; the scoreboard covers it.
- Structural/WAW stalls:
  - i_d_long while the FIFO is full and no pop this cycle → stall.
  - i_d_rfwe with busy[i_d_rda] → stall. This keeps writes in order.
- o_stall is asserted only when i_d_valid is 1. Register x0 never hazards and never forwards; its operand is forced to 0.
- Forward priority per port (youngest first): stage 0..NFWD-1 (valid & rfwe & !long & rda match), then same-cycle long completion, then i_rf_data.
  - sel encoding: 0..NFWD-1 = stage, NFWD = long completion, NFWD+1 = RF.
- i_flush suppresses issue and inserts a bubble. Older stages and scoreboard entries are unaffected.
- o_stall_cnt increments on each cycle with o_stall=1 and saturates at 0xFFFFFFFF.
- Reset mid-operation clears all state in the next cycle. Outstanding long ops are forgotten.

Decomposition:
- Package hazard_pkg holds:
  - RAW derivation function
  - stage entry struct
  - fwd-select encoding constants (SEL_LONG, SEL_RF)
  - x0 constant
- Sub-module long_tag_fifo (depth MAX_LONG, width RAW; push/pop/full/empty/head; simultaneous push+pop at full is legal).

Test Plan:
- add x5 at stage 0 (result 0x11), next decode reads x5 on port 0 → o_fwd_sel=0, o_fwd_data=0x11, no stall.
- Load to x7 issued, decode uses x7, i_long_done after 3 cycles with data 0xAB → stall for exactly 3 cycles; on the done cycle o_fwd_sel=NFWD, data 0xAB, o_d_issue=1; o_stall_cnt=3.
- Issue 4 loads (MAX_LONG=4) to x1..x4, fifth load decoded → o_long_full=1, stall. Assert i_long_done the same cycle → issue proceeds, FIFO head=x2.
- Jump reading x9 while stage 0 writes x9 → 1 stall cycle, then forwarding from stage 1.
- Decode reads x0 while stage 0 writes x0 with 0xFFFF → operand 0, no stall. i_flush with valid decode → o_d_issue=0 and stage 0 gets a bubble.
- i_hold for 2 cycles during a long op; i_long_done arrives during the hold → busy bit clears, pipeline frozen. rst mid-stream → busy vector 0, o_stall_cnt 0 next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the decode hazard / forwarding unit.
package hazard_pkg;

  // Register-address width for a register file of nreg entries.
  function automatic int raw_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // Widest register address a tracking entry can hold (up to 256 registers).
  localparam int RA_MAX = 8;

  // Architectural zero register: never hazards, never forwards.
  localparam int X0 = 0;

  // Forward-select codes sit just above the stage indices 0..nfwd-1.
  function automatic int sel_long(input int nfwd);
    return nfwd;
  endfunction

  function automatic int sel_rf(input int nfwd);
    return nfwd + 1;
  endfunction

  // One slot of the execute-onward tracking pipeline.
  typedef struct packed {
    logic              vld;
    logic [RA_MAX-1:0] rda;
    logic              rfwe;
    logic              is_long;
  } stg_ent_t;

endpackage

// File: rtl/long_tag_fifo.sv
// In-order FIFO of destination tags for outstanding variable-latency ops.
// Push and pop in the same cycle are legal even when full.
module long_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_push, do_pop;

  // A pop on an empty FIFO is dropped; a push at full needs a same-cycle pop.
  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rp_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + AW'(1);
    if (do_pop)  rp_d = (rp_q == AW'(DEPTH - 1)) ? '0 : rp_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  // Pointer / count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Tag storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard detection, operand forwarding and issue control for
// the in-order pipeline, with a scoreboard for variable-latency results.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int NRP      = 2,
  parameter  int NFWD     = 2,
  parameter  int MAX_LONG = 4,
  localparam int RAW      = raw_w(NREG),
  localparam int SW       = $clog2(NFWD + 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_d_valid,
  input  logic [NRP*RAW-1:0]  i_d_rsa,
  input  logic [NRP-1:0]      i_d_rs_used,
  input  logic [RAW-1:0]      i_d_rda,
  input  logic                i_d_rfwe,
  input  logic                i_d_long,
  input  logic                i_d_jump,
  input  logic                i_flush,
  input  logic                i_hold,
  input  logic [NRP*XLEN-1:0] i_rf_data,
  input  logic [NFWD*XLEN-1:0] i_stg_data,
  input  logic                i_long_done,
  input  logic [XLEN-1:0]     i_long_data,
  output logic [RAW-1:0]      o_long_rda,
  output logic [NRP*XLEN-1:0] o_fwd_data,
  output logic [NRP*SW-1:0]   o_fwd_sel,
  output logic                o_stall,
  output logic                o_d_issue,
  output logic                o_long_full,
  output logic [31:0]         o_stall_cnt
);
  localparam int SEL_LONG = sel_long(NFWD);
  localparam int SEL_RF   = sel_rf(NFWD);

  stg_ent_t [NFWD-1:0] stg_q;
  stg_ent_t            dec_ent;
  logic [NREG-1:0]     busy_q, busy_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                f_push, f_pop, f_full, f_empty;
  logic [RAW-1:0]      f_head;
  logic [NRP-1:0]      port_haz;
  logic                st_long, st_waw;

  // Completion is only real when something is outstanding.
  assign f_pop = i_long_done & ~f_empty;

  long_tag_fifo #(.DEPTH(MAX_LONG), .W(RAW)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .data_i  (i_d_rda),
    .full_o  (f_full),
    .empty_o (f_empty),
    .head_o  (f_head)
  );

  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [RAW-1:0]  rsa;
    logic            nz, long_hit, found, took;
    logic [SW-1:0]   sel;
    logic [XLEN-1:0] data;

    assign rsa      = i_d_rsa[p*RAW +: RAW];
    assign nz       = (rsa != RAW'(X0));
    assign long_hit = f_pop & (f_head == rsa);

    // Youngest matching stage wins; a matching long entry shadows older
    // stages and defers to the completion bus / register file instead.
    always_comb begin
      found = 1'b0;
      took  = 1'b0;
      sel   = SW'(SEL_RF);
      data  = i_rf_data[p*XLEN +: XLEN];
      for (int k = 0; k < NFWD; k++) begin
        if (!found && stg_q[k].vld && stg_q[k].rfwe && stg_q[k].rda == RA_MAX'(rsa)) begin
          found = 1'b1;
          if (!stg_q[k].is_long) begin
            took = 1'b1;
            sel  = SW'(k);
            data = i_stg_data[k*XLEN +: XLEN];
          end
        end
      end
      if (!took && long_hit) begin
        sel  = SW'(SEL_LONG);
        data = i_long_data;
      end
      if (!nz) begin
        sel  = SW'(SEL_RF);
        data = '0;
      end
    end

    // Busy register not retiring now, or a decode branch needing an
    // execute result that only appears at the end of this cycle.
    assign port_haz[p] = i_d_rs_used[p] & nz &
                         ((busy_q[rsa] & ~long_hit) |
                          (i_d_jump & stg_q[0].vld & stg_q[0].rfwe &
                           (stg_q[0].rda == RA_MAX'(rsa))));

    assign o_fwd_sel[p*SW +: SW]     = sel;
    assign o_fwd_data[p*XLEN +: XLEN] = data;
  end

  assign st_long     = i_d_long & f_full & ~f_pop;
  assign st_waw      = i_d_rfwe & busy_q[i_d_rda];
  assign o_stall     = i_d_valid & ((|port_haz) | st_long | st_waw);
  assign o_d_issue   = i_d_valid & ~o_stall & ~i_hold & ~i_flush;
  assign f_push      = o_d_issue & i_d_long & i_d_rfwe & (i_d_rda != RAW'(X0));
  assign o_long_full = f_full;
  assign o_long_rda  = f_head;
  assign o_stall_cnt = cnt_q;

  // Entry entering execute: the decode instruction on issue, else a bubble.
  always_comb begin
    dec_ent = '0;
    if (o_d_issue) begin
      dec_ent.vld     = 1'b1;
      dec_ent.rda     = RA_MAX'(i_d_rda);
      dec_ent.rfwe    = i_d_rfwe;
      dec_ent.is_long = i_d_long;
    end
  end

  // Scoreboard and stall-counter next state; WAW stall keeps set/clear disjoint.
  always_comb begin
    busy_d = busy_q;
    if (f_pop)  busy_d[f_head]  = 1'b0;
    if (f_push) busy_d[i_d_rda] = 1'b1;
    cnt_d = cnt_q;
    if (o_stall && cnt_q != '1) cnt_d = cnt_q + 32'd1;
  end

  // Tracking pipeline shifts unless the whole machine is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= '0;
    end else if (!i_hold) begin
      stg_q[0] <= dec_ent;
      for (int k = 1; k < NFWD; k++) stg_q[k] <= stg_q[k-1];
    end
  end

  // Scoreboard and counter; completions are accepted even while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // A completion with nothing outstanding means the backend lost track.
  a_done_empty: assert property (@(posedge clk) disable iff (rst) !(i_long_done && f_empty));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: expectations are queued as each decode cycle is driven
// and compared against the DUT at the following falling edge.
module tb_hazard_ctrl;
  localparam int XLEN = 32, NREG = 32, NRP = 2, NFWD = 2, MAX_LONG = 4;
  localparam int RAW = 5, SW = 2;

  logic                 clk = 1'b0, rst;
  logic                 i_d_valid, i_d_rfwe, i_d_long, i_d_jump, i_flush, i_hold, i_long_done;
  logic [NRP*RAW-1:0]   i_d_rsa;
  logic [NRP-1:0]       i_d_rs_used;
  logic [RAW-1:0]       i_d_rda;
  logic [NRP*XLEN-1:0]  i_rf_data;
  logic [NFWD*XLEN-1:0] i_stg_data;
  logic [XLEN-1:0]      i_long_data;
  logic [RAW-1:0]       o_long_rda;
  logic [NRP*XLEN-1:0]  o_fwd_data;
  logic [NRP*SW-1:0]    o_fwd_sel;
  logic                 o_stall, o_d_issue, o_long_full;
  logic [31:0]          o_stall_cnt;

  hazard_ctrl #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NFWD(NFWD), .MAX_LONG(MAX_LONG)) dut (
    .clk(clk), .rst(rst), .i_d_valid(i_d_valid), .i_d_rsa(i_d_rsa), .i_d_rs_used(i_d_rs_used),
    .i_d_rda(i_d_rda), .i_d_rfwe(i_d_rfwe), .i_d_long(i_d_long), .i_d_jump(i_d_jump),
    .i_flush(i_flush), .i_hold(i_hold), .i_rf_data(i_rf_data), .i_stg_data(i_stg_data),
    .i_long_done(i_long_done), .i_long_data(i_long_data), .o_long_rda(o_long_rda),
    .o_fwd_data(o_fwd_data), .o_fwd_sel(o_fwd_sel), .o_stall(o_stall), .o_d_issue(o_d_issue),
    .o_long_full(o_long_full), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {S_STALL, S_ISSUE, S_SEL0, S_DAT0, S_SEL1, S_DAT1, S_FULL, S_CNT, S_HEAD} sig_e;
  typedef struct {
    string       tag;
    sig_e        id;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e id);
    case (id)
      S_STALL: return 32'(o_stall);
      S_ISSUE: return 32'(o_d_issue);
      S_SEL0:  return 32'(o_fwd_sel[SW-1:0]);
      S_DAT0:  return o_fwd_data[XLEN-1:0];
      S_SEL1:  return 32'(o_fwd_sel[2*SW-1:SW]);
      S_DAT1:  return o_fwd_data[2*XLEN-1:XLEN];
      S_FULL:  return 32'(o_long_full);
      S_CNT:   return o_stall_cnt;
      S_HEAD:  return 32'(o_long_rda);
      default: return 'x;
    endcase
  endfunction

  task automatic ex(input string tag, input sig_e id, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.val = v;
    sbq.push_back(e);
  endtask

  // Check queued expectations mid-cycle, then let the clock edge commit.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, observe(e.id), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_d_valid = 0; i_d_rsa = '0; i_d_rs_used = '0; i_d_rda = '0; i_d_rfwe = 0;
    i_d_long = 0; i_d_jump = 0; i_flush = 0; i_hold = 0; i_long_done = 0; i_long_data = '0;
  endtask

  task automatic dec(input int rd, input bit we, input bit lng,
                     input int rs0, input int rs1, input logic [1:0] used, input bit jmp);
    i_d_valid = 1; i_d_rda = RAW'(rd); i_d_rfwe = we; i_d_long = lng;
    i_d_rsa = {RAW'(rs1), RAW'(rs0)}; i_d_rs_used = used; i_d_jump = jmp;
  endtask

  task automatic dat(input logic [31:0] s0, s1, r0, r1);
    i_stg_data = {s1, s0};
    i_rf_data  = {r1, r0};
  endtask

  initial begin
    idle();
    dat(0, 0, 0, 0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset state
    ex("rst_stall", S_STALL, 0); ex("rst_issue", S_ISSUE, 0);
    ex("rst_full", S_FULL, 0);   ex("rst_cnt", S_CNT, 0);
    cyc();

    // forwarding from stage 0, stage 1 and the register file
    idle(); dec(5, 1, 0, 0, 0, 2'b00, 0);
    ex("fw_a_issue", S_ISSUE, 1); cyc();
    idle(); dec(6, 1, 0, 5, 0, 2'b01, 0); dat(32'h11, 32'h22, 32'h99, 32'h98);
    ex("fw_b_sel0", S_SEL0, 0); ex("fw_b_dat0", S_DAT0, 32'h11);
    ex("fw_b_stall", S_STALL, 0); ex("fw_b_dat1_x0", S_DAT1, 0); cyc();
    idle(); dec(0, 0, 0, 5, 10, 2'b11, 0); dat(32'h33, 32'h22, 32'hA0, 32'hA1);
    ex("fw_c_sel0", S_SEL0, 1); ex("fw_c_dat0", S_DAT0, 32'h22);
    ex("fw_c_sel1", S_SEL1, 3); ex("fw_c_dat1", S_DAT1, 32'hA1); cyc();

    // load to x7, consumer stalls three cycles, takes the completion value
    idle(); dec(7, 1, 1, 0, 0, 2'b00, 0);
    ex("ld_issue", S_ISSUE, 1); cyc();
    for (int i = 0; i < 3; i++) begin
      idle(); dec(8, 1, 0, 7, 0, 2'b01, 0); dat(0, 0, 32'h55, 0);
      ex("ld_wait_stall", S_STALL, 1); ex("ld_wait_issue", S_ISSUE, 0);
      ex("ld_wait_head", S_HEAD, 7); ex("ld_wait_cnt", S_CNT, 32'(i));
      cyc();
    end
    idle(); dec(8, 1, 0, 7, 0, 2'b01, 0); dat(0, 0, 32'h55, 0);
    i_long_done = 1; i_long_data = 32'hAB;
    ex("ld_done_stall", S_STALL, 0); ex("ld_done_issue", S_ISSUE, 1);
    ex("ld_done_sel", S_SEL0, NFWD); ex("ld_done_dat", S_DAT0, 32'hAB);
    ex("ld_done_cnt", S_CNT, 3); cyc();
    idle(); ex("ld_after_cnt", S_CNT, 3); cyc();

    // fill the tag FIFO, fifth load waits for a same-cycle completion
    for (int r = 1; r <= 4; r++) begin
      idle(); dec(r, 1, 1, 0, 0, 2'b00, 0);
      ex("fill_issue", S_ISSUE, 1); ex("fill_full", S_FULL, 0); cyc();
    end
    idle(); dec(5, 1, 1, 0, 0, 2'b00, 0);
    ex("full_stall", S_STALL, 1); ex("full_issue", S_ISSUE, 0);
    ex("full_flag", S_FULL, 1); ex("full_head", S_HEAD, 1); cyc();
    idle(); dec(5, 1, 1, 0, 0, 2'b00, 0); i_long_done = 1;
    ex("full_pop_stall", S_STALL, 0); ex("full_pop_issue", S_ISSUE, 1); cyc();
    idle();
    ex("full_after_head", S_HEAD, 2); ex("full_after_full", S_FULL, 1);
    ex("full_after_cnt", S_CNT, 4); cyc();
    for (int r = 2; r <= 5; r++) begin
      idle(); i_long_done = 1;
      ex("drain_head", S_HEAD, 32'(r)); ex("drain_full", S_FULL, (r == 2) ? 1 : 0); cyc();
    end

    // decode branch on an execute-stage result: one stall, then stage 1
    idle(); dec(9, 1, 0, 0, 0, 2'b00, 0); ex("jmp_prod_issue", S_ISSUE, 1); cyc();
    idle(); dec(0, 0, 0, 9, 0, 2'b01, 1); dat(32'h900, 32'h901, 32'h5, 0);
    ex("jmp_stall", S_STALL, 1); ex("jmp_stall_issue", S_ISSUE, 0); cyc();
    idle(); dec(0, 0, 0, 9, 0, 2'b01, 1); dat(32'h900, 32'h901, 32'h5, 0);
    ex("jmp_go_stall", S_STALL, 0); ex("jmp_go_issue", S_ISSUE, 1);
    ex("jmp_go_sel", S_SEL0, 1); ex("jmp_go_dat", S_DAT0, 32'h901);
    ex("jmp_go_cnt", S_CNT, 5); cyc();

    // x0 never hazards or forwards; flush drops the decode instruction
    idle(); dec(0, 1, 0, 0, 0, 2'b00, 0); ex("x0_prod_issue", S_ISSUE, 1); cyc();
    idle(); dec(0, 0, 0, 0, 0, 2'b11, 1); dat(32'hFFFF, 32'hFFFF, 32'h1234, 32'h5678);
    ex("x0_stall", S_STALL, 0); ex("x0_dat0", S_DAT0, 0); ex("x0_dat1", S_DAT1, 0);
    ex("x0_issue", S_ISSUE, 1); cyc();
    idle(); dec(11, 1, 0, 0, 0, 2'b00, 0); i_flush = 1;
    ex("flush_issue", S_ISSUE, 0); ex("flush_stall", S_STALL, 0); cyc();
    idle(); dec(0, 0, 0, 11, 0, 2'b01, 0); dat(32'hDEAD, 32'hBEEF, 32'h77, 0);
    ex("flush_bubble_sel", S_SEL0, 3); ex("flush_bubble_dat", S_DAT0, 32'h77); cyc();

    // hold freezes the pipeline but still accepts a completion
    idle(); dec(12, 1, 1, 0, 0, 2'b00, 0); ex("hold_ld_issue", S_ISSUE, 1); cyc();
    idle(); dec(13, 1, 0, 0, 0, 2'b00, 0); ex("hold_add_issue", S_ISSUE, 1); cyc();
    idle(); dec(14, 1, 0, 0, 0, 2'b00, 0); i_hold = 1;
    ex("hold_issue", S_ISSUE, 0); ex("hold_stall", S_STALL, 0); cyc();
    idle(); i_hold = 1; i_long_done = 1; i_long_data = 32'h5A;
    ex("hold_done_head", S_HEAD, 12); cyc();
    idle(); dec(0, 0, 0, 13, 12, 2'b11, 0); dat(32'h130, 32'h120, 32'hB0, 32'hB1);
    ex("unhold_stall", S_STALL, 0); ex("unhold_issue", S_ISSUE, 1);
    ex("unhold_sel0", S_SEL0, 0); ex("unhold_dat0", S_DAT0, 32'h130);
    ex("unhold_sel1", S_SEL1, 3); ex("unhold_dat1", S_DAT1, 32'hB1);
    ex("unhold_full", S_FULL, 0); cyc();

    // reset in the middle of an outstanding load
    idle(); dec(20, 1, 1, 0, 0, 2'b00, 0); ex("mrst_ld_issue", S_ISSUE, 1); cyc();
    idle(); dec(21, 1, 0, 20, 0, 2'b01, 0); dat(0, 0, 32'hC0, 0);
    ex("mrst_pre_stall", S_STALL, 1); ex("mrst_pre_cnt", S_CNT, 5); cyc();
    rst = 1; cyc();
    rst = 0;
    ex("mrst_stall", S_STALL, 0); ex("mrst_issue", S_ISSUE, 1);
    ex("mrst_cnt", S_CNT, 0); ex("mrst_full", S_FULL, 0);
    ex("mrst_sel", S_SEL0, 3); ex("mrst_dat", S_DAT0, 32'hC0); cyc();

    idle();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
